unary_arith_unit: RTL and testbench
===================================

# unary_arith_unit

Parametrised successor to the single-function unary multiplier: consumes two serial unary bit-streams of `INPUT_WIDTH` bits, counts their ones, combines them under a run-time selected mode (multiply, scaled add, min, max) and re-emits the result as an `INPUT_WIDTH`-bit unary stream with output backpressure. It sits between unary stream producers and consumers in the unary datapath and replaces fixed-function units where mode flexibility is needed.

## Interface
- `INPUT_WIDTH`, 8, stream length in bits; power of two, ≥2
- `COUNT_WIDTH`, `$clog2(INPUT_WIDTH+1)`, width of ones/bit counters
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `a`, `b`  in  1 each  serial input bits
- `ready`  in  2  `ready[0]` qualifies `a`, `ready[1]` qualifies `b`
- `mode`  in  2  00 MUL, 01 SCALED_ADD, 10 MIN, 11 MAX
- `out_ready`  in  1  consumer accepts `y` this cycle
- `y`  out  1  output stream bit
- `valid`  out  1  `y` is meaningful
- `busy`  out  1  high in COMPUTE/EMIT; input bits ignored
- `y_ones`  out  COUNT_WIDTH  registered result ones count

## Operation
- States: COLLECT → COMPUTE → EMIT → COLLECT.
- COLLECT: per channel, on each edge with its `ready` bit high and bit count < `INPUT_WIDTH`, ones += bit, bits += 1. Bits offered to a full channel are dropped. Channels fill independently, in any interleaving.
- Both bit counts == `INPUT_WIDTH` → COMPUTE next edge; `mode` sampled on that same edge.
- COMPUTE (1 cycle): `y_ones` registered:
  - MUL: (a_ones·b_ones + W/2) >> log2(W), product width 2·COUNT_WIDTH
  - SCALED_ADD: (a_ones + b_ones + 1) >> 1
  - MIN / MAX: min/max of a_ones, b_ones
  - result ≤ W always; no saturation logic needed.
- EMIT: `valid`=1; bit index k advances only on edges with `valid && out_ready`; `y` held stable while stalled. Default encoding thermometer, LSB-first: y(k) = (k < y_ones). After bit W−1 is accepted → COLLECT, counters cleared.
- `reset` asserted at any time (mid-COLLECT, stalled EMIT): all state cleared immediately; partial streams discarded.

## Timing
- Reset values: `y`=0, `valid`=0, `busy`=0, `y_ones`=0, state COLLECT, counters 0.
- Edge E accepts final input bit → COMPUTE after E; `valid` rises after E+1; bit 0 visible cycle E+2.
- Unstalled EMIT: W cycles; next COLLECT begins cycle after last accepted output bit.
- `busy` high exactly while state ∈ {COMPUTE, EMIT}; `ready` in those states has no effect.

## Configuration
- `UNARY_DITHER_EN` defined: EMIT uses error-diffusion encoding. Accumulator (COUNT_WIDTH+1 bits) cleared on COMPUTE; per accepted bit: if acc + y_ones ≥ W, then y=1, acc += y_ones − W; else y=0, acc += y_ones. Total ones still equals `y_ones` exactly.
- Undefined: thermometer encoding only; no accumulator.

## Structure
- Package `unary_pkg`: `unary_mode_e` (MUL/SCALED_ADD/MIN/MAX), `unary_state_e` (COLLECT/COMPUTE/EMIT).
- Sub-module `unary_stream_counter` (ones + bit counter, saturating bit count, `full` flag), instantiated for `a` and `b`.

## Test plan
- W=8, MUL, a_ones=3 (00000111), b_ones=5 → y_ones=2, stream 0x03; first `valid` 2 cycles after last input edge.
- MUL 8×8 → 0xFF; MUL 0×8 → 0x00; SCALED_ADD 3,4 → y_ones=4, stream 0x0F; MIN 2,6 → 0x03; MAX 2,6 → 0x3F.
- `a` fills 3 cycles before `b`; extra `a` bits with ready[0]=1 are ignored → result unchanged.
- `out_ready` low 3 cycles after bit 2 → `y`, `valid` held, 11 EMIT cycles total, stream identical.
- `reset` pulsed mid-EMIT → all outputs 0 immediately; next operation correct from a clean start.
- `UNARY_DITHER_EN`, SCALED_ADD result 4 → stream 0xAA (bits 1,3,5,7).

Source files
------------

// File: rtl/unary_pkg.sv
// unary_pkg: shared types for the unary arithmetic unit.
// Result mode encoding and top-level control states.
package unary_pkg;

  typedef enum logic [1:0] {
    MUL        = 2'b00,
    SCALED_ADD = 2'b01,
    MIN        = 2'b10,
    MAX        = 2'b11
  } unary_mode_e;

  typedef enum logic [1:0] {
    COLLECT = 2'b00,
    COMPUTE = 2'b01,
    EMIT    = 2'b10
  } unary_state_e;

endpackage : unary_pkg

// File: rtl/unary_stream_counter.sv
// unary_stream_counter: per-channel ones counter and saturating bit counter.
// Bits offered once INPUT_WIDTH bits have been taken are dropped.
// fill_now flags the edge on which the final bit is being accepted, so the
// parent can leave COLLECT on that same edge.
module unary_stream_counter
  import unary_pkg::*;
#(
  parameter int INPUT_WIDTH = 8,
  parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   en,
  input  logic                   bit_in,
  output logic [COUNT_WIDTH-1:0] ones,
  output logic                   full,
  output logic                   fill_now
);

  localparam logic [COUNT_WIDTH-1:0] FULL_CNT = COUNT_WIDTH'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(INPUT_WIDTH - 1);

  logic [COUNT_WIDTH-1:0] ones_reg;
  logic [COUNT_WIDTH-1:0] bits_reg;
  logic                   accept;

  assign full     = (bits_reg == FULL_CNT);
  assign accept   = en && !full;
  assign fill_now = accept && (bits_reg == LAST_CNT);
  assign ones     = ones_reg;

  // Accumulate ones and bit count until the channel holds a full stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones_reg <= '0;
      bits_reg <= '0;
    end else if (clear) begin
      ones_reg <= '0;
      bits_reg <= '0;
    end else if (accept) begin
      ones_reg <= ones_reg + COUNT_WIDTH'(bit_in);
      bits_reg <= bits_reg + 1'b1;
    end
  end

endmodule : unary_stream_counter

// File: rtl/unary_arith_unit.sv
// unary_arith_unit: collects two serial unary streams, combines their ones
// counts (MUL / SCALED_ADD / MIN / MAX) and re-emits the result as a unary
// stream with output backpressure.
// Build option: define UNARY_DITHER_EN for error-diffusion output encoding;
// otherwise the output stream is thermometer coded, LSB first.
module unary_arith_unit
  import unary_pkg::*;
#(
  parameter int INPUT_WIDTH = 8,
  parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a,
  input  logic                   b,
  input  logic [1:0]             ready,
  input  logic [1:0]             mode,
  input  logic                   out_ready,
  output logic                   y,
  output logic                   valid,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] y_ones
);

  localparam int LOG2_W = $clog2(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0]   LAST_IDX  = COUNT_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [2*COUNT_WIDTH-1:0] MUL_ROUND = (2*COUNT_WIDTH)'(INPUT_WIDTH / 2);

  unary_state_e           state_reg;
  unary_state_e           state_next;
  unary_mode_e            mode_reg;
  logic [COUNT_WIDTH-1:0] y_ones_reg;
  logic [COUNT_WIDTH-1:0] k_reg;

  logic [1:0]             ch_bit;
  logic [COUNT_WIDTH-1:0] ch_ones [2];
  logic [1:0]             ch_full;
  logic [1:0]             ch_fill;

  logic collect_en;
  logic collect_done;
  logic emit_accept;
  logic emit_done;

  assign ch_bit       = {b, a};
  assign collect_en   = (state_reg == COLLECT);
  assign collect_done = collect_en && (&(ch_full | ch_fill));
  assign emit_accept  = (state_reg == EMIT) && out_ready;
  assign emit_done    = emit_accept && (k_reg == LAST_IDX);

  // Channel 0 counts a, channel 1 counts b; both cleared once the output stream completes.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      unary_stream_counter #(
        .INPUT_WIDTH(INPUT_WIDTH),
        .COUNT_WIDTH(COUNT_WIDTH)
      ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (emit_done),
        .en       (collect_en && ready[gi]),
        .bit_in   (ch_bit[gi]),
        .ones     (ch_ones[gi]),
        .full     (ch_full[gi]),
        .fill_now (ch_fill[gi])
      );
    end
  endgenerate

  // Result arithmetic. The rounding bits shifted out and the always-zero
  // high bits are split off explicitly; the result never exceeds W.
  logic [2*COUNT_WIDTH-1:0]        prod_sum;
  logic [COUNT_WIDTH-LOG2_W-1:0]   mul_hi_unused;
  logic [COUNT_WIDTH-1:0]          mul_res;
  logic [LOG2_W-1:0]               mul_lo_unused;
  logic [COUNT_WIDTH:0]            add_sum;
  logic [COUNT_WIDTH-1:0]          add_res;
  logic                            add_lo_unused;
  logic [COUNT_WIDTH-1:0]          result;

  assign prod_sum = ({{COUNT_WIDTH{1'b0}}, ch_ones[0]} * {{COUNT_WIDTH{1'b0}}, ch_ones[1]}) + MUL_ROUND;
  assign {mul_hi_unused, mul_res, mul_lo_unused} = prod_sum;
  assign add_sum = {1'b0, ch_ones[0]} + {1'b0, ch_ones[1]} + (COUNT_WIDTH+1)'(1);
  assign {add_res, add_lo_unused} = add_sum;

  // Select the combined ones count according to the mode latched at end of COLLECT.
  always_comb begin
    result = mul_res;
    case (mode_reg)
      MUL:        result = mul_res;
      SCALED_ADD: result = add_res;
      MIN:        result = (ch_ones[0] < ch_ones[1]) ? ch_ones[0] : ch_ones[1];
      MAX:        result = (ch_ones[0] > ch_ones[1]) ? ch_ones[0] : ch_ones[1];
      default:    result = mul_res;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: leave COLLECT on the edge both channels become full.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (collect_done) state_next = COMPUTE;
      COMPUTE: state_next = EMIT;
      EMIT:    if (emit_done) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // Latch mode, register the result and step the output bit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_reg   <= MUL;
      y_ones_reg <= '0;
      k_reg      <= '0;
    end else begin
      if (collect_done) begin
        mode_reg <= unary_mode_e'(mode);
      end
      if (state_reg == COMPUTE) begin
        y_ones_reg <= result;
        k_reg      <= '0;
      end else if (emit_accept) begin
        k_reg <= emit_done ? '0 : k_reg + 1'b1;
      end
    end
  end

  assign valid  = (state_reg == EMIT);
  assign busy   = (state_reg != COLLECT);
  assign y_ones = y_ones_reg;

`ifdef UNARY_DITHER_EN
  localparam logic [COUNT_WIDTH:0] FULL_W = (COUNT_WIDTH+1)'(INPUT_WIDTH);

  logic [COUNT_WIDTH:0] acc_reg;
  logic [COUNT_WIDTH:0] dither_sum;
  logic                 dither_hit;

  assign dither_sum = acc_reg + {1'b0, y_ones_reg};
  assign dither_hit = (dither_sum >= FULL_W);
  assign y          = valid && dither_hit;

  // Error-diffusion accumulator: restarts each COMPUTE, advances per accepted bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg <= '0;
    end else if (state_reg == COMPUTE) begin
      acc_reg <= '0;
    end else if (emit_accept) begin
      acc_reg <= dither_hit ? (dither_sum - FULL_W) : dither_sum;
    end
  end
`else
  // Thermometer code: the first y_ones bits of the stream are ones.
  assign y = valid && (k_reg < y_ones_reg);
`endif

endmodule : unary_arith_unit

// File: tb/tb_unary_arith_unit.sv
// tb_unary_arith_unit: directed self-checking bench for unary_arith_unit (W=8).
// Expected streams depend on whether UNARY_DITHER_EN is defined.
module tb_unary_arith_unit;

  logic       clk;
  logic       reset;
  logic       a;
  logic       b;
  logic [1:0] ready;
  logic [1:0] mode;
  logic       out_ready;
  logic       y;
  logic       valid;
  logic       busy;
  logic [3:0] y_ones;

  int total;
  int bad;

`ifdef UNARY_DITHER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif

  unary_arith_unit #(.INPUT_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .mode      (mode),
    .out_ready (out_ready),
    .y         (y),
    .valid     (valid),
    .busy      (busy),
    .y_ones    (y_ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed both streams LSB first; b starts b_delay cycles late while a keeps
  // being offered ones (which must be dropped once a is full).
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input int b_delay);
    for (int c = 0; c < 8 + b_delay; c++) begin
      ready[0] = 1'b1;
      a        = (c < 8) ? av[c] : 1'b1;
      ready[1] = (c >= b_delay);
      b        = (c >= b_delay) ? bv[c - b_delay] : 1'b0;
      tick();
    end
    ready = 2'b00;
    a     = 1'b0;
    b     = 1'b0;
  endtask

  // One full operation: collect, check COMPUTE/EMIT timing, capture the stream.
  task automatic run_op(input string name, input logic [1:0] m, input logic [7:0] av,
                        input logic [7:0] bv, input int b_delay, input int exp_ones,
                        input logic [7:0] exp_therm, input logic [7:0] exp_dith,
                        input int stall_at, input int stall_len);
    logic [7:0] s;
    logic       y0;
    int         vc;
    s  = 8'h00;
    vc = 0;
    mode = m;
    out_ready = 1'b1;
    send(av, bv, b_delay);
    chk({name, " busy_compute"}, busy, 1);
    chk({name, " valid_compute"}, valid, 0);
    tick();
    chk({name, " valid_first"}, valid, 1);
    chk({name, " y_ones"}, y_ones, exp_ones);
    for (int k = 0; k < 8; k++) begin
      if (k == stall_at) begin
        for (int st = 0; st < stall_len; st++) begin
          if (valid === 1'b1) vc++;
          y0 = y;
          out_ready = 1'b0;
          tick();
          chk({name, " y_held"}, y, y0);
          chk({name, " valid_held"}, valid, 1);
        end
      end
      out_ready = 1'b1;
      if (valid === 1'b1) vc++;
      s[k] = y;
      tick();
    end
    $display("op %s: mode=%0d y_ones=%0d stream=%02h valid_cycles=%0d", name, m, y_ones, s, vc);
    chk({name, " stream"}, s, DITHER ? exp_dith : exp_therm);
    chk({name, " valid_cycles"}, vc, 8 + stall_len);
    chk({name, " valid_after"}, valid, 0);
    chk({name, " busy_after"}, busy, 0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    a         = 1'b0;
    b         = 1'b0;
    ready     = 2'b00;
    mode      = 2'b00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst y", y, 0);
    chk("rst valid", valid, 0);
    chk("rst busy", busy, 0);
    chk("rst y_ones", y_ones, 0);
    reset = 1'b0;
    tick();

    // name, mode, a, b, b_delay, ones, thermometer, dither, stall_at, stall_len
    run_op("mul_3x5",   2'b00, 8'h07, 8'h1F, 0, 2, 8'h03, 8'h88, 99, 0);
    run_op("mul_8x8",   2'b00, 8'hFF, 8'hFF, 0, 8, 8'hFF, 8'hFF, 99, 0);
    run_op("mul_0x8",   2'b00, 8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 99, 0);
    run_op("sadd_3_4",  2'b01, 8'h07, 8'h0F, 0, 4, 8'h0F, 8'hAA, 99, 0);
    run_op("min_2_6",   2'b10, 8'h03, 8'h3F, 0, 2, 8'h03, 8'h88, 99, 0);
    run_op("max_2_6",   2'b11, 8'h03, 8'h3F, 0, 6, 8'h3F, 8'hEE, 99, 0);
    run_op("stagger",   2'b00, 8'h07, 8'h1F, 3, 2, 8'h03, 8'h88, 99, 0);
    run_op("stall",     2'b11, 8'h03, 8'h3F, 0, 6, 8'h3F, 8'hEE, 3, 3);

    // Reset in the middle of EMIT clears everything without waiting for a clock edge.
    mode = 2'b11;
    out_ready = 1'b1;
    send(8'h03, 8'h3F, 0);
    tick();
    tick();
    tick();
    chk("mid valid_pre", valid, 1);
    #2;
    reset = 1'b1;
    #1;
    $display("reset mid-emit: y=%0b valid=%0b busy=%0b y_ones=%0d", y, valid, busy, y_ones);
    chk("mid y", y, 0);
    chk("mid valid", valid, 0);
    chk("mid busy", busy, 0);
    chk("mid y_ones", y_ones, 0);
    #1;
    reset = 1'b0;
    tick();
    chk("mid busy_after", busy, 0);
    run_op("post_rst",  2'b10, 8'h03, 8'h3F, 0, 2, 8'h03, 8'h88, 99, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_unary_arith_unit
